// File: rtl/sram_memory_pkg.sv
// rtl/sram_memory_pkg.sv - shared constants, op decode and byte-mask expansion for sram_memory
package sram_memory_pkg;

  localparam int SRAM_WIDTH_DEF = 16;
  localparam int SRAM_DEPTH_DEF = 16;
  localparam int SRAM_MAX_BYTES = 64;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_READ,
    OP_WRITE
  } op_e;

  function automatic op_e decode_op(input logic ce, input logic we);
    if (!ce) return OP_IDLE;
    return we ? OP_WRITE : OP_READ;
  endfunction

  // Sized for the widest supported word; callers truncate to their WIDTH.
  function automatic logic [SRAM_MAX_BYTES*8-1:0] byte_mask_expand(
    input logic [SRAM_MAX_BYTES-1:0] wmask
  );
    logic [SRAM_MAX_BYTES*8-1:0] bits;
    for (int j = 0; j < SRAM_MAX_BYTES; j++) bits[8*j +: 8] = {8{wmask[j]}};
    return bits;
  endfunction

endpackage

// File: rtl/sram_memory_port.sv
// rtl/sram_memory_port.sv - one SRAM port: op decode, range check, bit enables, registered read data
module sram_memory_port
  import sram_memory_pkg::*;
#(
  parameter int WIDTH = SRAM_WIDTH_DEF,
  parameter int DEPTH = SRAM_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [WIDTH/8-1:0] wmask,
  input  logic [WIDTH-1:0]   rd_word,
  output logic               wr_en,
  output logic [WIDTH-1:0]   bit_en,
  output logic [WIDTH-1:0]   rdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  op_e  op;
  logic in_range;

  assign op       = decode_op(ce, we);
  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign wr_en    = (op == OP_WRITE) && in_range;
  assign bit_en   = WIDTH'(byte_mask_expand(SRAM_MAX_BYTES'(wmask)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (op == OP_READ) begin
      rdata <= in_range ? rd_word : '0;
    end
  end

endmodule

// File: rtl/sram_memory.sv
// rtl/sram_memory.sv - true dual-port byte-masked SRAM; SRAM_MEMORY_CLEAR_EN clears the array on reset
module sram_memory
  import sram_memory_pkg::*;
#(
  parameter int WIDTH = SRAM_WIDTH_DEF,
  parameter int DEPTH = SRAM_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce_a,
  input  logic               we_a,
  input  logic [AW-1:0]      addr_a,
  input  logic [WIDTH/8-1:0] wmask_a,
  input  logic [WIDTH-1:0]   wdata_a,
  output logic [WIDTH-1:0]   rdata_a,
  input  logic               ce_b,
  input  logic               we_b,
  input  logic [AW-1:0]      addr_b,
  input  logic [WIDTH/8-1:0] wmask_b,
  input  logic [WIDTH-1:0]   wdata_b,
  output logic [WIDTH-1:0]   rdata_b
);

  if (WIDTH % 8 != 0 || WIDTH < 8 || WIDTH > 8*SRAM_MAX_BYTES) begin : g_bad_width
    $error("sram_memory: WIDTH must be a non-zero multiple of 8 within the supported range");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("sram_memory: DEPTH must be at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_en_a, wr_en_b;
  logic [WIDTH-1:0] bit_en_a, bit_en_b;
  logic [WIDTH-1:0] rd_word_a, rd_word_b;

  assign rd_word_a = mem[addr_a];
  assign rd_word_b = mem[addr_b];

  sram_memory_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_port_a (
    .clk(clk), .rst_n(rst_n), .ce(ce_a), .we(we_a), .addr(addr_a), .wmask(wmask_a),
    .rd_word(rd_word_a), .wr_en(wr_en_a), .bit_en(bit_en_a), .rdata(rdata_a)
  );

  sram_memory_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_port_b (
    .clk(clk), .rst_n(rst_n), .ce(ce_b), .we(we_b), .addr(addr_b), .wmask(wmask_b),
    .rd_word(rd_word_b), .wr_en(wr_en_b), .bit_en(bit_en_b), .rdata(rdata_b)
  );

  // Port B is applied first so that port A's later assignment wins on shared bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef SRAM_MEMORY_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`endif
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (wr_en_b && bit_en_b[i]) mem[addr_b][i] <= wdata_b[i];
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (wr_en_a && bit_en_a[i]) mem[addr_a][i] <= wdata_a[i];
      end
    end
  end

endmodule

// File: tb/tb_sram_memory.sv
// tb/tb_sram_memory.sv - directed self-checking bench for sram_memory
module tb_sram_memory;

  logic        clk;
  logic        rst_n;
  logic        ce_a, we_a, ce_b, we_b;
  logic [3:0]  addr_a, addr_b;
  logic [1:0]  wmask_a, wmask_b;
  logic [15:0] wdata_a, wdata_b;
  logic [15:0] rdata_a, rdata_b;

  int tests;
  int fails;
  logic [15:0] exp_mem [16];

  sram_memory dut (
    .clk(clk), .rst_n(rst_n),
    .ce_a(ce_a), .we_a(we_a), .addr_a(addr_a), .wmask_a(wmask_a), .wdata_a(wdata_a), .rdata_a(rdata_a),
    .ce_b(ce_b), .we_b(we_b), .addr_b(addr_b), .wmask_b(wmask_b), .wdata_b(wdata_b), .rdata_b(rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    ce_a = 1'b1; we_a = 1'b1; addr_a = a; wdata_a = d; wmask_a = m;
    step();
    ce_a = 1'b0; we_a = 1'b0;
  endtask

  task automatic read_b(input logic [3:0] a);
    ce_b = 1'b1; we_b = 1'b0; addr_b = a;
    step();
    ce_b = 1'b0;
  endtask

  task automatic read_a(input logic [3:0] a);
    ce_a = 1'b1; we_a = 1'b0; addr_a = a;
    step();
    ce_a = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    ce_a = 0; we_a = 0; addr_a = 0; wmask_a = 0; wdata_a = 0;
    ce_b = 0; we_b = 0; addr_b = 0; wmask_b = 0; wdata_b = 0;

    step(); step();
    check("reset_rdata_a", rdata_a, 16'h0000);
    check("reset_rdata_b", rdata_b, 16'h0000);
    rst_n = 1'b1;

    // Fill every word through A, then read back through B.
    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = 16'($urandom);
      write_a(4'(i), exp_mem[i], 2'b11);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      read_b(4'(i));
      check($sformatf("fill_read_%0d", i), rdata_b, exp_mem[i]);
    end

    write_a(4'd3, 16'hAAAA, 2'b11);
    write_a(4'd3, 16'h1234, 2'b01);
    read_b(4'd3);
    check("partial_mask_low", rdata_b, 16'hAA34);

    write_a(4'd3, 16'h56FF, 2'b10);
    read_b(4'd3);
    check("partial_mask_high", rdata_b, 16'h5634);

    // Read-first on a same-edge cross-port write.
    write_a(4'd5, 16'h0001, 2'b11);
    ce_a = 1; we_a = 1; addr_a = 4'd5; wdata_a = 16'hBEEF; wmask_a = 2'b11;
    ce_b = 1; we_b = 0; addr_b = 4'd5;
    step();
    ce_a = 0; we_a = 0; ce_b = 0;
    check("rdw_old_word", rdata_b, 16'h0001);
    read_b(4'd5);
    check("rdw_new_word", rdata_b, 16'hBEEF);

    // Dual write collision: A wins on shared bytes.
    ce_a = 1; we_a = 1; addr_a = 4'd7; wdata_a = 16'h1111; wmask_a = 2'b11;
    ce_b = 1; we_b = 1; addr_b = 4'd7; wdata_b = 16'h2222; wmask_b = 2'b11;
    step();
    wmask_a = 2'b01; wmask_b = 2'b10;
    wdata_a = 16'h3311; wdata_b = 16'h2244;
    read_b(4'd7);
    ce_a = 0; we_a = 0; we_b = 0;
    check("collide_full_masks", rdata_b, 16'h1111);
    ce_a = 1; we_a = 1; ce_b = 1; we_b = 1;
    step();
    ce_a = 0; we_a = 0; ce_b = 0; we_b = 0;
    read_b(4'd7);
    check("collide_split_masks", rdata_b, 16'h2211);

    // Hold with ce_b low while other inputs wander.
    write_a(4'd2, 16'h5A5A, 2'b11);
    read_b(4'd2);
    check("hold_initial", rdata_b, 16'h5A5A);
    for (int i = 0; i < 5; i++) begin
      ce_b = 0; we_b = 1'(i); addr_b = 4'(i + 8); wdata_b = 16'hFFFF; wmask_b = 2'b11;
      step();
      check($sformatf("hold_cycle_%0d", i), rdata_b, 16'h5A5A);
    end
    we_b = 0;
    read_b(4'd8);
    check("hold_no_write", rdata_b, exp_mem[8]);

    // Zero-mask write leaves memory and rdata untouched.
    read_a(4'd3);
    check("zero_mask_pre", rdata_a, 16'h5634);
    write_a(4'd3, 16'h0000, 2'b00);
    check("zero_mask_rdata_hold", rdata_a, 16'h5634);
    read_b(4'd3);
    check("zero_mask_mem", rdata_b, 16'h5634);

    read_a(4'd2);
    check("pre_reset_rdata_a", rdata_a, 16'h5A5A);

    // Asynchronous reset between edges.
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_rdata_a", rdata_a, 16'h0000);
    check("async_reset_rdata_b", rdata_b, 16'h0000);
    ce_b = 1; we_b = 0; addr_b = 4'd7;
    ce_a = 1; we_a = 1; addr_a = 4'd9; wdata_a = 16'hDEAD; wmask_a = 2'b11;
    step();
    check("reset_ignores_read", rdata_b, 16'h0000);
    ce_a = 0; we_a = 0;
    rst_n = 1'b1;
    step();
    ce_b = 0;
`ifdef SRAM_MEMORY_CLEAR_EN
    check("post_reset_addr7", rdata_b, 16'h0000);
`else
    check("post_reset_addr7", rdata_b, 16'h2211);
`endif
    read_b(4'd9);
`ifdef SRAM_MEMORY_CLEAR_EN
    check("reset_ignores_write", rdata_b, 16'h0000);
`else
    check("reset_ignores_write", rdata_b, exp_mem[9]);
`endif
    read_a(4'd2);
`ifdef SRAM_MEMORY_CLEAR_EN
    check("post_reset_addr2", rdata_a, 16'h0000);
`else
    check("post_reset_addr2", rdata_a, 16'h5A5A);
`endif

    // Both ports reading one word.
    write_a(4'd12, 16'hC3A5, 2'b11);
    ce_a = 1; we_a = 0; addr_a = 4'd12;
    ce_b = 1; we_b = 0; addr_b = 4'd12;
    step();
    ce_a = 0; ce_b = 0;
    check("dual_read_a", rdata_a, 16'hC3A5);
    check("dual_read_b", rdata_b, 16'hC3A5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_memory.md
Name: sram_memory

Overview:
- Parameterised true dual-port synchronous SRAM model: two independent ports (A, B), each able to read or write one word per clock.
- Byte-granular write masks on both ports.
- Used as on-chip event/frame buffer storage; one port typically writes and the other reads.

Parameters:
- WIDTH, 16, word width in bits; must be a multiple of 8 (elaboration-time assertion).
- DEPTH, 16, number of words; address width AW = $clog2(DEPTH), DEPTH >= 2.

Ports:
- clk  in  1  rising-edge clock for both ports.
- rst_n  in  1  asynchronous active-low reset.
- ce_a  in  1  port A chip enable, active high.
- we_a  in  1  port A write enable, active high; read when ce_a=1 and we_a=0.
- addr_a  in  AW  port A word address.
- wmask_a  in  WIDTH/8  port A byte write mask; bit j enables bits [8j+7:8j].
- wdata_a  in  WIDTH  port A write data.
- rdata_a  out  WIDTH  port A registered read data.
- ce_b, we_b, addr_b, wmask_b, wdata_b, rdata_b: port B, identical semantics.

Behaviour:
- Operation per port at each rising clk edge:
  - ce=0: idle; rdata holds its previous value; we, addr, wmask and wdata are ignored.
  - ce=1, we=1: write. For each byte j with wmask[j]=1, mem[addr][8j+:8] <= wdata[8j+:8]. Unmasked bytes are unchanged. rdata holds.
  - ce=1, we=0: read. rdata <= mem[addr] at that edge. Data is valid after the edge, i.e. one-cycle latency, and stays until the next read on that port.
- Reset:
  - rst_n=0 asynchronously clears rdata_a and rdata_b to 0.
  - The array is not reset; see Optional Feature.
  - Operations are ignored while rst_n=0.
  - Release is synchronous-safe: the first operation is taken at the first clk edge with rst_n=1.
- Cross-port read during write to the same address, same edge: read-first. The reader gets the old word; the new word is visible on the next read.
- Both ports write the same address on the same edge:
  - Port A wins for bytes enabled in both masks.
  - Bytes enabled only in wmask_b take port B data.
- Both ports reading the same address: both return the same word.
- Write with wmask=0: no change to memory; counts as a write, so rdata holds.
- Address >= DEPTH (non-power-of-2 DEPTH):
  - Writes are dropped.
  - Reads return 0.
- The array is a plain logic [WIDTH-1:0] mem [DEPTH] inferred memory. No combinational path exists from inputs to rdata.

Optional Feature:
- Macro SRAM_MEMORY_CLEAR_EN.
- When defined: asserting rst_n=0 also clears every array word to 0 asynchronously, so a read of any unwritten address after reset returns 0.
- When undefined: array contents are untouched by reset and power up undefined (X in simulation); only the rdata registers are reset.

Decomposition:
- Package sram_memory_pkg holds:
  - default constants SRAM_WIDTH_DEF=16 and SRAM_DEPTH_DEF=16;
  - the function byte_mask_expand(wmask) returning a WIDTH-bit bit-enable vector;
  - the op enum (OP_IDLE, OP_READ, OP_WRITE) decoded from {ce, we}.
- One sub-module is natural: sram_memory_port (per-port decode, masked write enable, rdata register), instantiated twice around the shared array.
- Write-collision priority is resolved in the top level.

Test Plan:
- Write all 16 addresses via port A (wmask_a=2'b11, random data, one write every two cycles), then read each via port B with ce_b pulsed for one cycle -> rdata_b equals the written word one edge after the read; zero mismatches.
- Partial mask: write 16'hAAAA to addr 3, then write 16'h1234 with wmask_a=2'b01 -> read returns 16'hAA34.
- Same-edge port A write of 16'hBEEF to addr 5 and port B read of addr 5 (previously 16'h0001) -> rdata_b=16'h0001; next read gives 16'hBEEF.
- Dual write to addr 7: A writes 16'h1111 with mask 2'b11, B writes 16'h2222 with mask 2'b11 -> read returns 16'h1111. Repeat with mask_a=2'b01, mask_b=2'b10 -> 16'h2211.
- Hold: read addr 2 (16'h5A5A), then hold ce_b=0 for 5 cycles while addr_b changes -> rdata_b stays 16'h5A5A.
- Reset mid-operation: pulse rst_n low asynchronously between edges -> rdata_a and rdata_b go to 0 immediately. Array contents persist without SRAM_MEMORY_CLEAR_EN and read back as 0 with it.
